// File: rtl/regfile_wb.sv
// Architectural integer register file fed by the MEM/WB write-back port.
// Two combinational read ports with same-cycle write-to-read bypass and a committed-write counter.
module regfile_wb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wb_rd_data,
   input  logic [ADDR_W-1:0] wb_rd_addr,
   input  logic              wb_rd_enable,
   input  logic              rs1_enable,
   input  logic [ADDR_W-1:0] rs1_addr,
   output logic [DATA_W-1:0] rs1_data,
   input  logic              rs2_enable,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs2_data,
   output logic [CNT_W-1:0]  wr_count
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [CNT_W-1:0]  wr_count_q;
   logic              wr_in_range;
   logic              commit;

   logic [1:0]        rd_en;
   logic [1:0]        rd_in_range;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   assign rd_en      = {rs2_enable, rs1_enable};
   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;
   assign rs1_data   = rd_data[0];
   assign rs2_data   = rd_data[1];
   assign wr_count   = wr_count_q;

   // Range checks only exist when the index space is larger than the array.
   if (NUM_REGS < (2 ** ADDR_W)) begin : g_range
      assign wr_in_range    = (32'(wb_rd_addr) < NUM_REGS);
      assign rd_in_range[0] = (32'(rs1_addr) < NUM_REGS);
      assign rd_in_range[1] = (32'(rs2_addr) < NUM_REGS);
   end else begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 2'b11;
   end

   assign commit = wb_rd_enable && (wb_rd_addr != '0) && wr_in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else if (commit) begin
         mem_q[wb_rd_addr] <= wb_rd_data;
         wr_count_q        <= wr_count_q + CNT_W'(1);
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
         rd_data[p] = '0;
         if (rst || !rd_en[p] || (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
         end else if (wb_rd_enable && (wb_rd_addr == rd_addr[p])) begin
            rd_data[p] = wb_rd_data;
         end else if (rd_in_range[p]) begin
            rd_data[p] = mem_q[rd_addr[p]];
         end
      end
   end

endmodule
